ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage. Generates the PC, reads the instruction ROM through its
//  synchronous 1-cycle-latency port, and buffers returned words in a small FIFO.
//  Presents {pc, inst} to decode with a valid/ready handshake.
//  Sits between the SoC instruction ROM and the core decode stage.
//  Accepts a PC redirect (jump/branch) from execute.
// PARAMETERS
//  DATA_WIDTH  32           instruction and PC width
//  RESET_PC    32'h0        first fetch address after reset (byte address)
//  FIFO_DEPTH  2            fetch buffer entries; power of two, >=2
// PORTS
//  i_sys_clk     in   1           system clock, rising edge
//  i_sys_rst_n   in   1           asynchronous active-low reset
//  o_rom_en      out  1           ROM read strobe
//  o_rom_addr    out  DATA_WIDTH  byte address; ROM indexes addr[..:2]
//  i_rom_data    in   DATA_WIDTH  read data, valid the cycle after o_rom_en
//  i_jmp_en      in   1           redirect request, single-cycle pulse
//  i_jmp_pc      in   DATA_WIDTH  redirect target; bits [1:0] ignored (forced 0)
//  o_inst_valid  out  1           buffered instruction available
//  i_inst_ready  in   1           decode accepts; transfer when valid&&ready
//  o_inst        out  DATA_WIDTH  instruction word (FIFO head)
//  o_inst_pc     out  DATA_WIDTH  PC of o_inst
// BEHAVIOUR
//  Reset (async assert, sync deassert): o_rom_en=0, o_rom_addr=RESET_PC, o_inst_valid=0,
//   o_inst=0, o_inst_pc=0, FIFO empty, in-flight flag clear, state=IDLE.
//  FSM: IDLE -> FETCH the first cycle after reset release; no issue in IDLE.
//   FETCH -> REDIRECT on i_jmp_en; REDIRECT -> FETCH unconditionally after 1 cycle.
//  Issue rule (FETCH only): o_rom_en=1 when (count - pop + inflight) < FIFO_DEPTH,
//   where pop = o_inst_valid && i_inst_ready.
//   On issue: pc <= pc+4 (mod 2^DATA_WIDTH wrap), inflight <= 1, and the request pc
//   is recorded for the response.
//  Response: the cycle after issue, {req_pc, i_rom_data} is pushed into the FIFO;
//   o_inst_valid rises the following cycle (issue N -> data N+1 -> valid N+2).
//  Steady state with ready held high: one instruction per cycle.
//  FIFO: head drives o_inst/o_inst_pc; push and pop in the same cycle is legal
//   at any occupancy, count unchanged. Overflow is impossible by the issue rule;
//   a push when full is an assertion failure.
//  Redirect (i_jmp_en in FETCH or REDIRECT):
//   - FIFO flushed; o_inst_valid=0 next cycle.
//   - any in-flight response is discarded (not pushed).
//   - pc <= {i_jmp_pc[DW-1:2],2'b00}; no issue in the redirect cycle or in REDIRECT.
//   - first fetch of the target is issued in the following FETCH cycle.
//   - i_jmp_en in IDLE is ignored.
//   - i_jmp_en with pop in the same cycle: the pop still completes, then the flush applies.
//  o_inst/o_inst_pc hold their value while valid&&!ready (no change until the transfer).
//  Reset mid-operation: every register returns immediately to its reset value;
//   in-flight data is lost.
// CONFIGURATION
//  IFU_PERF_CNT_EN defined:
//   - adds o_perf_fetch (32b, count of words pushed) and
//     o_perf_stall (32b, cycles with o_inst_valid && !i_inst_ready).
//   - both reset to 0 and saturate at all-ones.
//  Not defined: these ports and counters are absent; behaviour otherwise identical.
// STRUCTURE
//  ifu_pkg:
//   - typedef fetch_entry_t {pc, inst}
//   - fsm enum {IDLE, FETCH, REDIRECT}
//   - localparam PC_STEP=4
//  Sub-module ifu_fifo: parameterised synchronous FIFO of fetch_entry_t with
//   push/pop/flush, count, and a head-entry output.
// TESTING
//  1 Reset, ROM[i]=i, ready=1 -> addrs 0,4,8.. on consecutive cycles; first valid 3rd
//    cycle after release; inst sequence 0,1,2..
//  2 ready=0 for 10 cycles -> exactly FIFO_DEPTH words buffered, o_rom_en low,
//    o_inst stable; on release no word lost or duplicated.
//  3 i_jmp_en with i_jmp_pc=0x43 while one word is in flight -> in-flight word dropped;
//    next fetch addr 0x40; next delivered pc=0x40.
//  4 Jump in same cycle as a pop -> popped word observed once; all later words come
//    from the target.
//  5 RESET_PC=32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//  6 Reset asserted mid-stream -> outputs return to reset values asynchronously;
//    refetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
`timescale 1ns/1ps
package ifu_pkg;

    // Native fetch width; the default buffer entry is built from it.
    localparam int unsigned IFU_XLEN = 32;

    // Byte distance between consecutive sequential fetches.
    localparam int unsigned PC_STEP = 4;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] inst;
    } fetch_entry_t;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO for fetch results. It supports push, pop and flush,
// and exposes the occupancy count and the head entry. The depth must be a
// power of two so that the pointers wrap on their own. A flush beats a
// simultaneous push or pop.
`timescale 1ns/1ps
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 2,
    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  entry_t        i_entry,
    input  logic          i_pop,
    input  logic          i_flush,
    output entry_t        o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Next-state computation for storage, pointers and occupancy.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can leave one unassigned and infer a latch.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = i_pop && (count_q != '0);
        do_push  = i_push && (!o_full || do_pop);

        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, because the head entry drives visible outputs that must read zero out of reset.
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = (count_q == CW'(DEPTH));

    // The issue logic upstream must never push into a full buffer unless a pop frees a slot.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(i_push && o_full && !i_pop && !i_flush))
        else $error("ifu_fifo: push while full");

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage. It generates the PC, reads a ROM that has one cycle
// of latency, buffers the returned words and hands {pc, inst} to decode over a
// valid/ready handshake. A redirect from execute flushes the buffer and drops
// any response still in flight.
// Optional feature macro: IFU_PERF_CNT_EN adds saturating counters for
// fetched words and decode stall cycles.
`timescale 1ns/1ps
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    output logic                  o_rom_en,
    output logic [DATA_WIDTH-1:0] o_rom_addr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    input  logic                  i_jmp_en,
    input  logic [DATA_WIDTH-1:0] i_jmp_pc,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [DATA_WIDTH-1:0] o_inst_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           o_perf_fetch,
    output logic [31:0]           o_perf_stall
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    // Buffer entry sized to this instance's data width.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    fsm_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;

    logic                  pop;
    logic                  push;
    logic                  jmp_take;
    logic                  issue;
    logic [OW-1:0]         occupancy;
    logic [DATA_WIDTH-1:0] jmp_target;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    entry_t                fifo_head;
    entry_t                fifo_in;

    // Sequencer, issue decision and PC update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;

        pop        = o_inst_valid && i_inst_ready;
        jmp_take   = i_jmp_en && (state_q != IDLE);
        jmp_target = i_jmp_pc & ~DATA_WIDTH'(3);
        // A response that arrives while a redirect is taken is thrown away.
        push       = inflight_q && !jmp_take;
        fifo_in    = '{pc: req_pc_q, inst: i_rom_data};

        // Slots already promised: words held, minus the one leaving now, plus the one on its way.
        occupancy  = OW'(fifo_count) - OW'(pop) + OW'(inflight_q);
        issue      = (state_q == FETCH) && !jmp_take && (occupancy < OW'(FIFO_DEPTH));
        // The ROM answers in exactly one cycle, so in-flight is just last cycle's issue.
        inflight_d = issue;

        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (i_jmp_en) state_d = REDIRECT;
            REDIRECT: state_d = FETCH;
            default:  state_d = IDLE;
        endcase

        if (issue) begin
            pc_d     = pc_q + DATA_WIDTH'(PC_STEP);
            req_pc_d = pc_q;
        end
        if (jmp_take) begin
            pc_d = jmp_target;
        end
    end

    // Sequencer and PC registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    ifu_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_sys_clk),
        .rst_n   (i_sys_rst_n),
        .i_push  (push),
        .i_entry (fifo_in),
        .i_pop   (pop),
        .i_flush (jmp_take),
        .o_head  (fifo_head),
        .o_count (fifo_count),
        .o_full  (fifo_full)
    );

    assign o_rom_en     = issue;
    assign o_rom_addr   = pc_q;
    assign o_inst_valid = (fifo_count != '0);
    assign o_inst       = fifo_head.inst;
    assign o_inst_pc    = fifo_head.pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (push && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (o_inst_valid && !i_inst_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_perf_fetch = fetch_cnt_q;
    assign o_perf_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch. The main instance starts at PC 0 and is exercised with
// streaming, stalls, redirects and a mid-stream reset. A second instance
// starting at 0xFFFF_FFF8 streams continuously so that PC wrap can be observed.
// Both ROM models return word index = addr >> 2.
`timescale 1ns/1ps
module tb_ifu_fetch;

    localparam int          DW        = 32;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;
    localparam logic [31:0] W_RST_PC  = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance signals.
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = '0;
    logic        jmp_en;
    logic [31:0] jmp_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Wrap instance signals.
    logic        w_rom_en;
    logic [31:0] w_rom_addr;
    logic [31:0] w_rom_data = '0;
    logic        w_jmp_en   = 1'b0;
    logic [31:0] w_jmp_pc   = '0;
    logic        w_valid;
    logic        w_ready    = 1'b1;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall, w_perf_fetch, w_perf_stall;
`endif

    ifu_fetch #(.DATA_WIDTH(DW), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) u_dut (
        .i_sys_clk    (clk),
        .i_sys_rst_n  (rst_n),
        .o_rom_en     (rom_en),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .i_jmp_en     (jmp_en),
        .i_jmp_pc     (jmp_pc),
        .o_inst_valid (inst_valid),
        .i_inst_ready (inst_ready),
        .o_inst       (inst),
        .o_inst_pc    (inst_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .o_perf_fetch (perf_fetch),
        .o_perf_stall (perf_stall)
`endif
    );

    ifu_fetch #(.DATA_WIDTH(DW), .RESET_PC(W_RST_PC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .i_sys_clk    (clk),
        .i_sys_rst_n  (rst_n),
        .o_rom_en     (w_rom_en),
        .o_rom_addr   (w_rom_addr),
        .i_rom_data   (w_rom_data),
        .i_jmp_en     (w_jmp_en),
        .i_jmp_pc     (w_jmp_pc),
        .o_inst_valid (w_valid),
        .i_inst_ready (w_ready),
        .o_inst       (w_inst),
        .o_inst_pc    (w_inst_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .o_perf_fetch (w_perf_fetch),
        .o_perf_stall (w_perf_stall)
`endif
    );

    // Synchronous ROM models with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_en)   rom_data   <= rom_addr >> 2;
        if (w_rom_en) w_rom_data <= w_rom_addr >> 2;
    end

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] w_q[$];
    logic [31:0] w_pc;
    int          w_issued;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Scoreboard update for one sampled cycle of both instances.
    task automatic monitor();
        exp_t        e;
        logic [31:0] wp;
        if (rom_en) begin
            check("issue_addr", rom_addr, model_pc);
            e.pc   = model_pc;
            e.inst = model_pc >> 2;
            exp_q.push_back(e);
            model_pc = model_pc + 32'd4;
        end
        if (inst_valid && inst_ready) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("deliver_pc", inst_pc, e.pc);
                check("deliver_inst", inst, e.inst);
            end
        end
        if (jmp_en) begin
            check("no_issue_on_jmp", 32'(rom_en), 32'd0);
            exp_q.delete();
            model_pc = jmp_pc & ~32'd3;
        end
        if (w_rom_en) begin
            check("wrap_issue_addr", w_rom_addr, w_pc);
            if (w_issued == 2) check("t5_wrap_to_zero", w_rom_addr, 32'h0);
            w_q.push_back(w_pc);
            w_pc = w_pc + 32'd4;
            w_issued++;
        end
        if (w_valid && w_ready) begin
            check("wrap_sb_nonempty", 32'(w_q.size() != 0), 32'd1);
            if (w_q.size() != 0) begin
                wp = w_q.pop_front();
                check("wrap_deliver_pc", w_inst_pc, wp);
                check("wrap_deliver_inst", w_inst, wp >> 2);
            end
        end
    endtask

    // One cycle: drive inputs mid-cycle, let them settle, then sample.
    task automatic tick(input logic rdy, input logic jmp, input logic [31:0] jpc);
        @(negedge clk);
        inst_ready = rdy;
        jmp_en     = jmp;
        jmp_pc     = jpc;
        #1;
        monitor();
    endtask

    task automatic clear_models();
        exp_q.delete();
        w_q.delete();
        model_pc = RST_PC;
        w_pc     = W_RST_PC;
        w_issued = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rom_en"}, 32'(rom_en), 32'd0);
        check({tag, "_rom_addr"}, rom_addr, RST_PC);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_wrap_addr"}, w_rom_addr, W_RST_PC);
        check({tag, "_wrap_valid"}, 32'(w_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_ready = 1'b1;
        jmp_en     = 1'b0;
        jmp_pc     = '0;
        clear_models();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: streaming with ready high; first valid on the third cycle after release.
        tick(1'b1, 1'b0, '0);
        check("t1_en_c1", 32'(rom_en), 32'd1);
        check("t1_valid_c1", 32'(inst_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("t1_valid_c2", 32'(inst_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("t1_valid_c3", 32'(inst_valid), 32'd1);
        check("t1_first_inst", inst, 32'd0);
        check("t1_first_pc", inst_pc, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0);
            check("t1_stream_en", 32'(rom_en), 32'd1);
            check("t1_stream_valid", 32'(inst_valid), 32'd1);
        end

        // 2: decode stalls for 10 cycles; buffer fills, fetch stops, head holds.
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, '0);
            check("t2_valid", 32'(inst_valid), 32'd1);
            if (exp_q.size() != 0) begin
                check("t2_hold_pc", inst_pc, exp_q[0].pc);
                check("t2_hold_inst", inst, exp_q[0].inst);
            end
        end
        check("t2_en_low", 32'(rom_en), 32'd0);
        check("t2_buffered", 32'(exp_q.size()), 32'(DEPTH));
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);

        // 3: redirect to 0x43 while a word is in flight and decode is stalled.
        tick(1'b0, 1'b1, 32'h0000_0043);
        tick(1'b1, 1'b0, '0);
        check("t3_redirect_en", 32'(rom_en), 32'd0);
        check("t3_flushed", 32'(inst_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("t3_target_en", 32'(rom_en), 32'd1);
        check("t3_target_addr", rom_addr, 32'h0000_0040);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("t3_first_valid", 32'(inst_valid), 32'd1);
        check("t3_first_pc", inst_pc, 32'h0000_0040);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0);

        // 4: redirect in the same cycle as a pop.
        tick(1'b1, 1'b1, 32'h0000_0100);
        check("t4_pop_valid", 32'(inst_valid), 32'd1);
        tick(1'b1, 1'b0, '0);
        check("t4_flushed", 32'(inst_valid), 32'd0);
        tick(1'b1, 1'b0, '0);
        check("t4_target_addr", rom_addr, 32'h0000_0100);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("t4_first_pc", inst_pc, 32'h0000_0100);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);

        // 6: asynchronous reset in the middle of a stream.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_async");
        clear_models();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, '0);
        check("t6_restart_addr", rom_addr, RST_PC);
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        check("t6_restart_valid", 32'(inst_valid), 32'd1);
        check("t6_restart_pc", inst_pc, RST_PC);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
